// File: rtl/sprite_pkg.sv
// sprite_pkg: shared state encoding and byte-format constants for the sprite loader.
package sprite_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_PAL, LOAD_IMG} state_t;
  localparam int BYTES_PER_COLOR = 3;
  localparam int RGB_W = 8;
endpackage

// File: rtl/sprite_loader_rgb_packer.sv
// rgb_packer: gathers R,G,B stream bytes into one 24-bit palette word.
module rgb_packer
  import sprite_pkg::*;
(
  input  logic                             pixel_clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             en,
  input  logic [RGB_W-1:0]                 data,
  output logic [BYTES_PER_COLOR*RGB_W-1:0] word,
  output logic                             word_valid
);
  localparam logic [1:0] LAST = 2'(BYTES_PER_COLOR - 1);
  logic [1:0]       phase;
  logic [RGB_W-1:0] r, g;
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      r     <= '0;
      g     <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? 2'd0 : phase + 2'd1;
      if (phase == 2'd0) r <= data;
      if (phase == 2'd1) g <= data;
    end
  end
  // Blue is taken straight from the bus so the word is complete on the third byte.
  assign word       = {r, g, data};
  assign word_valid = en && (phase == LAST);
endmodule

// File: rtl/sprite_loader.sv
// sprite_loader: streams palette then raster image bytes into the sprite BRAM write ports.
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int WIDTH         = 256,
  parameter int HEIGHT        = 256,
  parameter int PALETTE_DEPTH = 256
) (
  input  logic                               pixel_clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [7:0]                         s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic                               pal_we,
  output logic [$clog2(PALETTE_DEPTH)-1:0]   pal_addr,
  output logic [23:0]                        pal_data,
  output logic                               img_we,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    img_addr,
  output logic [7:0]                         img_data,
  output logic                               busy,
  output logic                               done
);
  localparam int PA = $clog2(PALETTE_DEPTH);
  localparam int IA = $clog2(WIDTH*HEIGHT);
  state_t          state, nxt;
  logic [PA-1:0]   pal_cnt;
  logic [IA-1:0]   pix_cnt;
  logic            accept, start_go, pal_en, img_go, pal_go, last_pal, last_pix;
  logic [23:0]     word;
  assign s_ready  = (state != IDLE);
  assign busy     = (state != IDLE);
  assign accept   = s_valid && s_ready && !abort;
  assign start_go = start && (state == IDLE) && !abort;
  assign pal_en   = accept && (state == LOAD_PAL);
  assign img_go   = accept && (state == LOAD_IMG);
  assign last_pal = (pal_cnt == PA'(PALETTE_DEPTH - 1));
  assign last_pix = (pix_cnt == IA'(WIDTH*HEIGHT - 1));
  rgb_packer u_packer (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .clr        (abort || start_go),
    .en         (pal_en),
    .data       (s_data),
    .word       (word),
    .word_valid (pal_go)
  );
  always_comb
    nxt = abort             ? IDLE     :
          start_go          ? LOAD_PAL :
          (pal_go && last_pal) ? LOAD_IMG :
          (img_go && last_pix) ? IDLE     : state;
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pal_cnt  <= '0;
      pix_cnt  <= '0;
      pal_we   <= 1'b0;
      pal_addr <= '0;
      pal_data <= '0;
      img_we   <= 1'b0;
      img_addr <= '0;
      img_data <= '0;
      done     <= 1'b0;
    end else begin
      state   <= nxt;
      pal_we  <= pal_go;
      img_we  <= img_go;
      done    <= img_go && last_pix;
      pal_cnt <= (abort || start_go) ? '0 : pal_go ? (last_pal ? '0 : pal_cnt + 1'b1) : pal_cnt;
      pix_cnt <= (abort || start_go) ? '0 : img_go ? (last_pix ? '0 : pix_cnt + 1'b1) : pix_cnt;
      if (pal_go) begin
        pal_addr <= pal_cnt;
        pal_data <= word;
      end
      if (img_go) begin
        img_addr <= pix_cnt;
        img_data <= s_data;
      end
    end
  end
endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader: table-driven stream stimulus with a write scoreboard for sprite_loader.
module tb_sprite_loader;
  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, pal_we, img_we, busy, done;
  logic [1:0]  pal_addr;
  logic [23:0] pal_data;
  logic [3:0]  img_addr;
  logic [7:0]  img_data;
  int checks = 0, errors = 0;

  typedef struct {
    logic        img;
    logic [3:0]  addr;
    logic [23:0] data;
    logic        dn;
  } exp_t;
  typedef struct {
    logic [7:0]  b;
    logic        st;
    logic        wr;
    exp_t        e;
  } vec_t;
  exp_t exp_q[$];
  vec_t vecs[28];

  sprite_loader #(.WIDTH(4), .HEIGHT(4), .PALETTE_DEPTH(4)) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .busy(busy), .done(done)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write the DUT issues must match the oldest expectation.
  always @(posedge pixel_clk) begin
    #1;
    if (pal_we || img_we || done) begin
      check("one_we", 32'(pal_we && img_we), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("we_kind", {30'd0, img_we, pal_we}, e.img ? 32'd2 : 32'd1);
        check("wr_addr", e.img ? 32'(img_addr) : 32'(pal_addr), 32'(e.addr));
        check("wr_data", e.img ? 32'(img_data) : 32'(pal_data), 32'(e.data));
        check("done", 32'(done), 32'(e.dn));
        if (done) begin
          check("done_busy", 32'(busy), 32'd0);
          check("done_ready", 32'(s_ready), 32'd0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic st, input logic wr, input exp_t e);
    s_valid = 1'b1;
    s_data  = b;
    start   = st;
    check("s_ready", 32'(s_ready), 32'd1);
    if (wr && s_ready) exp_q.push_back(e);
    @(negedge pixel_clk);
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic pal_byte(input logic [7:0] b, input logic wr, input logic [1:0] a, input logic [23:0] d);
    exp_t e;
    e = '{img: 1'b0, addr: 4'(a), data: d, dn: 1'b0};
    send(b, 1'b0, wr, e);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge pixel_clk);
    start = 1'b0;
    check("ready_after_start", 32'(s_ready), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic do_abort();
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    @(posedge pixel_clk);
    #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(s_ready), 32'd0);
    @(negedge pixel_clk);
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      logic [7:0] e8;
      e8 = 8'(i / 3);
      vecs[i].b  = (i % 3 == 0) ? 8'hA0 + e8 : (i % 3 == 1) ? 8'hB0 + e8 : 8'hC0 + e8;
      vecs[i].st = (i == 7);
      vecs[i].wr = (i % 3 == 2);
      vecs[i].e  = '{img: 1'b0, addr: 4'(e8), data: {8'hA0 + e8, 8'hB0 + e8, 8'hC0 + e8}, dn: 1'b0};
    end
    for (int k = 0; k < 16; k++) begin
      vecs[12 + k].b  = 8'(k);
      vecs[12 + k].st = 1'b0;
      vecs[12 + k].wr = 1'b1;
      vecs[12 + k].e  = '{img: 1'b1, addr: 4'(k), data: 24'(k), dn: (k == 15)};
    end

    #3;
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {pal_we, img_we, done, 29'd0}, 32'd0);
    check("rst_addr", 32'(pal_addr) | 32'(img_addr), 32'd0);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    @(negedge pixel_clk);

    // Single palette triple
    do_start();
    pal_byte(8'h10, 1'b0, 2'd0, 24'h0);
    pal_byte(8'h20, 1'b0, 2'd0, 24'h0);
    pal_byte(8'h30, 1'b1, 2'd0, 24'h102030);
    @(negedge pixel_clk);
    do_abort();

    // Full load from table; start mid-stream must be ignored
    do_start();
    for (int i = 0; i < 28; i++) send(vecs[i].b, vecs[i].st, vecs[i].wr, vecs[i].e);
    // Now in the done cycle: a start here is honoured
    check("done_seen", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge pixel_clk);
    start = 1'b0;
    check("restart_ready", 32'(s_ready), 32'd1);
    pal_byte(8'h01, 1'b0, 2'd0, 24'h0);
    pal_byte(8'h02, 1'b0, 2'd0, 24'h0);
    pal_byte(8'h03, 1'b1, 2'd0, 24'h010203);
    do_abort();

    // Gap of 5 cycles between G and B
    do_start();
    pal_byte(8'h5A, 1'b0, 2'd0, 24'h0);
    pal_byte(8'h6B, 1'b0, 2'd0, 24'h0);
    repeat (5) @(negedge pixel_clk);
    pal_byte(8'h7C, 1'b1, 2'd0, 24'h5A6B7C);
    pal_byte(8'h11, 1'b0, 2'd1, 24'h0);
    do_abort();

    // Abort after two image bytes, then restart at palette address 0
    do_start();
    for (int i = 0; i < 14; i++) send(vecs[i].b, 1'b0, vecs[i].wr, vecs[i].e);
    do_abort();
    repeat (3) @(negedge pixel_clk);
    do_start();
    pal_byte(8'h44, 1'b0, 2'd0, 24'h0);
    pal_byte(8'h55, 1'b0, 2'd0, 24'h0);
    pal_byte(8'h66, 1'b1, 2'd0, 24'h445566);
    do_abort();

    // Asynchronous reset mid-image, between clock edges
    do_start();
    for (int i = 0; i < 15; i++) send(vecs[i].b, 1'b0, vecs[i].wr, vecs[i].e);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(s_ready), 32'd0);
    check("arst_busy_done", {busy, done, pal_we, img_we}, 32'd0);
    check("arst_pal", 32'(pal_addr) | 32'(pal_data), 32'd0);
    check("arst_img", 32'(img_addr) | 32'(img_data), 32'd0);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    @(negedge pixel_clk);
    do_start();
    pal_byte(8'h0A, 1'b0, 2'd0, 24'h0);
    pal_byte(8'h0B, 1'b0, 2'd0, 24'h0);
    pal_byte(8'h0C, 1'b1, 2'd0, 24'h0A0B0C);
    do_abort();

    repeat (3) @(negedge pixel_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_loader.md
# sprite_loader

Writer side of the sprite image and palette BRAMs. Accepts a byte stream over a valid/ready handshake, from the UART or host bridge, and writes it into both memories. First it fills the 24-bit palette BRAM, then the 8-bit palette-index image BRAM in raster order. Both memories are later read by the sprite display path in the pixel clock domain.

## Interface
- WIDTH, 256: sprite width in pixels.
- HEIGHT, 256: sprite height in pixels.
- PALETTE_DEPTH, 256: number of palette entries (24-bit RGB each).
- pixel_clk  in  1  sole clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a load; ignored unless idle.
- abort  in  1  synchronous cancel; returns the block to idle.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  block accepts a byte this cycle.
- pal_we  out  1  palette BRAM write enable.
- pal_addr  out  $clog2(PALETTE_DEPTH)  palette write address.
- pal_data  out  24  palette write data, {R,G,B}.
- img_we  out  1  image BRAM write enable.
- img_addr  out  $clog2(WIDTH*HEIGHT)  image write address.
- img_data  out  8  image write data (palette index).
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse when the load completes.

## Operation
- Stream format: PALETTE_DEPTH×3 bytes (R, G, B per entry, entry 0 first), then WIDTH×HEIGHT index bytes (row 0 column 0 first, column fastest).
- A byte is accepted when s_valid && s_ready.
- States:
  - IDLE: s_ready=0. start → LOAD_PAL, with all counters cleared.
  - LOAD_PAL: s_ready=1. Bytes 0 and 1 of each triple are latched as R and G. On byte 2, the write is issued and the entry counter increments. After entry PALETTE_DEPTH-1 is written, the state moves to LOAD_IMG.
  - LOAD_IMG: s_ready=1. Each accepted byte is one image write, and the pixel counter increments. On pixel WIDTH*HEIGHT-1 the state moves to IDLE and done pulses.
- busy = (state != IDLE).
- start while busy: ignored.
- abort in any state: the next state is IDLE and counters clear. No write is issued for a byte accepted in the same cycle as abort. Partially written BRAM contents are left as-is, and done does not pulse.
- s_valid low: all state is held. Gaps of any length are legal, including mid-triple.
- Counters never wrap in normal operation, because the state changes at the terminal count. The pixel counter is exactly $clog2(WIDTH*HEIGHT) bits wide, and the address is the plain counter value, with no multiply.
- Reset (async, any time, including mid-load):
  - state=IDLE and all counters 0.
  - s_ready, pal_we, img_we, busy and done are 0.
  - pal_addr, pal_data, img_addr and img_data are 0.

## Timing
- s_ready is decoded from the registered state only. It has no combinational dependence on s_valid.
- Write outputs are registered:
  - A byte accepted at edge t produces pal_we or img_we high for exactly the cycle after t, with address and data stable in that cycle.
  - The write enable is low in every other cycle.
- Palette write latency is 1 cycle after the B byte is accepted. Image write latency is 1 cycle after each accepted byte.
- At most one write enable is high in any cycle.
- done is high in the same cycle as the final img_we.
  - busy is already 0 in that cycle, and s_ready is 0.
  - A start in that cycle is honoured.
- Throughput: one byte per cycle while s_valid is held high. A full default load takes 768 + 65536 accepted bytes.

## Structure
- Package sprite_pkg holds:
  - the state enum (IDLE, LOAD_PAL, LOAD_IMG);
  - BYTES_PER_COLOR = 3;
  - the RGB field-width constant (8).
- One natural sub-module, rgb_packer: a 2-bit byte-phase counter plus R and G holding registers. It emits a 24-bit word and a word-valid strobe on the third byte, and clears on abort or start.
- Counters and the FSM live in sprite_loader. There is no BRAM inside the block; the write ports connect to the port-B side of the display memories.

## Test plan
- Reset release then start, stream bytes 0x10,0x20,0x30: pal_we pulses once, one cycle after the 0x30 handshake, with pal_addr=0 and pal_data=0x102030. No img_we occurs.
- Full load with WIDTH=HEIGHT=4, PALETTE_DEPTH=4: 12 palette bytes then 16 indices 0..15.
  - Four pal_we pulses, at addresses 0..3.
  - Sixteen img_we pulses, with img_addr=img_data=0..15.
  - done pulses with the 16th write, then busy=0 and s_ready=0.
- s_valid deasserted for 5 cycles between the G and B bytes: no write during the gap, and the correct {R,G,B} is written after the B byte.
- abort asserted after 2 image bytes: no further writes, busy=0 next cycle, and done is never seen. A new start then restarts at pal_addr=0.
- rst_n asserted asynchronously mid-LOAD_IMG (between clock edges): every output reads 0 immediately. start pressed while busy is ignored (its counters are unaffected).
- start in the same cycle as done: the next load begins, s_ready=1 in the following cycle, and the first palette write goes to address 0.
